// File: rtl/strobe_pacer.sv
// Paces bursty single-cycle strobes so output strobes are at least GAP cycles apart.
// Optional dropped-strobe counter is enabled by defining STROBE_PACER_DROP_CNT_EN.
module strobe_pacer #(
    parameter int CNT_W = 8,
    parameter int GAP   = 8
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             strb_in,
    input  logic             ovf_clr,
    output logic             strb_out,
    output logic [CNT_W-1:0] pending,
    output logic             busy,
    output logic             overflow,
    output logic [15:0]      drop_cnt
);

    generate
        if (GAP < 1 || GAP > 255) begin : g_bad_gap
            $error("strobe_pacer: GAP must be in 1..255");
        end
        if (CNT_W < 2 || CNT_W > 16) begin : g_bad_cnt_w
            $error("strobe_pacer: CNT_W must be in 2..16");
        end
    endgenerate

    localparam logic [7:0] GAP_LOAD = 8'(GAP - 1);

    logic [7:0]       gap_cnt;
    logic             fire;
    logic             full;
    logic             drop;
    logic [CNT_W-1:0] pending_nxt;

    // A strobe arriving at a full counter is only accepted if one leaves on the same edge.
    always_comb begin
        fire        = (pending != '0 || strb_in) && gap_cnt == 8'd0;
        full        = &pending;
        drop        = strb_in && full && !fire;
        pending_nxt = pending;
        if (strb_in && !fire && !full) begin
            pending_nxt = pending + 1'b1;
        end else if (!strb_in && fire) begin
            pending_nxt = pending - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            strb_out <= 1'b0;
            pending  <= '0;
            gap_cnt  <= 8'd0;
            overflow <= 1'b0;
        end else begin
            strb_out <= fire;
            pending  <= pending_nxt;
            if (fire) begin
                gap_cnt <= GAP_LOAD;
            end else if (gap_cnt != 8'd0) begin
                gap_cnt <= gap_cnt - 8'd1;
            end
            // A drop on the same edge as a clear keeps the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    assign busy = (pending != '0);

`ifdef STROBE_PACER_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            drop_cnt_q <= 16'd0;
        end else if (drop && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = 16'd0;
`endif

endmodule

// File: doc/strobe_pacer.md
STROBE_PACER -- requirements
Module: strobe_pacer

Interface
REQ-001 Parameter CNT_W, default 8: pending-strobe counter width, legal range 2..16.
REQ-002 Parameter GAP, default 8: minimum clk cycles between output strobe rising edges, legal range 1..255; an out-of-range value SHALL cause an elaboration error.
REQ-003 One clock; reset is synchronous and active-low.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 nrst  input  1  synchronous active-low reset.
REQ-006 strb_in  input  1  single-cycle input strobe; bursty, back-to-back allowed.
REQ-007 ovf_clr  input  1  clears the sticky overflow flag.
REQ-008 strb_out  output  1  paced single-cycle strobe, registered; feeds cdc_strobe strb1.
REQ-009 pending  output  CNT_W  registered count of accepted but not yet emitted strobes.
REQ-010 busy  output  1  high while pending != 0.
REQ-011 overflow  output  1  sticky flag: one or more strobes dropped.
REQ-012 drop_cnt  output  16  dropped-strobe count (see Configuration).

Function
REQ-013 fire SHALL be high when (pending != 0 or strb_in) and gap_cnt == 0; strb_out SHALL register fire.
REQ-014 Latency: with gap_cnt == 0 and pending == 0, strb_in sampled at edge N SHALL drive strb_out high for exactly the cycle after edge N.
REQ-015 On each edge, pending SHALL update to pending + strb_in - fire, where strb_in and fire are each 0 or 1.
REQ-016 strb_in and fire on the same edge SHALL leave pending unchanged.
REQ-017 gap_cnt (8 bits, internal) SHALL load GAP-1 on fire, decrement by 1 when nonzero, and hold at 0 otherwise.
REQ-018 Consecutive strb_out pulses SHALL be exactly GAP cycles apart while pending stays nonzero, and never less than GAP cycles apart.
REQ-019 With GAP=1, continuous strb_in SHALL produce continuous strb_out with pending held at 0.
REQ-020 A strobe SHALL be dropped when strb_in is high, pending == 2^CNT_W-1 and fire is low; pending SHALL hold its maximum and never wrap.
REQ-021 At pending == 2^CNT_W-1 with fire high, strb_in SHALL be accepted and not counted as dropped.
REQ-022 On any drop, overflow SHALL be set on the same edge.
REQ-023 ovf_clr SHALL clear overflow on the next edge; if a drop and ovf_clr occur together, set SHALL win.
REQ-024 The number of strb_out pulses SHALL equal the number of strb_in pulses minus the number of drops, counting from reset until pending reaches 0.

Reset
REQ-025 nrst low at an edge SHALL force strb_out=0, pending=0, busy=0, overflow=0, drop_cnt=0 and gap_cnt=0.
REQ-026 Reset mid-operation SHALL discard all pending strobes; no strb_out SHALL follow reset until a new strb_in arrives.
REQ-027 The first strb_in after reset release SHALL fire per REQ-014, with no initial gap.

Configuration
REQ-028 Macro STROBE_PACER_DROP_CNT_EN: when defined, drop_cnt SHALL increment by 1 per drop, saturate at 16'hFFFF, and be unaffected by ovf_clr.
REQ-029 When STROBE_PACER_DROP_CNT_EN is not defined, drop_cnt SHALL be tied to 0, the port SHALL remain present, and no counter logic SHALL be synthesized.

Verification
REQ-030 Idle, GAP=8, one strb_in -> strb_out high one cycle later for one cycle; pending stays 0; busy stays 0.
REQ-031 GAP=8, 5 back-to-back strb_in -> 5 strb_out pulses spaced exactly 8 cycles apart; pending peaks at 4, then returns to 0.
REQ-032 CNT_W=3, GAP=8, 20 back-to-back strb_in -> 3 fires during the burst, pending saturates at 7, overflow=1, drop_cnt=10 (macro on), 10 strb_out pulses in total.
REQ-033 overflow=1, ovf_clr pulsed on the same edge as a drop -> overflow stays 1; ovf_clr pulsed alone -> overflow=0 on the next edge.
REQ-034 nrst pulled low for 1 cycle with pending=5 -> pending=0 and strb_out=0 on the next edge; no further strb_out without new strb_in.
REQ-035 GAP=1, strb_in held high for 50 cycles -> strb_out high for 50 consecutive cycles with a 1-cycle lag; pending=0 throughout.
